// File: rtl/chain_max_select.sv
// chain_max_select
//   Reduction stage of the chaining DP. Each input beat carries one
//   (anchor i, predecessor j) pair: the pair score, f[j] and j. The beats of one
//   anchor are folded into its best chain score f[i] and predecessor p[i], and
//   one result per anchor is presented on a valid/ready output.
//
//   Pipeline: stage 1 registers the beat (with the saturated candidate score),
//   stage 2 is the accumulator plus the output register. A result appears two
//   edges after its last beat is accepted when the output is not stalled.
//
//   Optional feature, enabled by defining CHAIN_MAX_SKIP_EN: after MAX_SKIP
//   consecutive non-improving valid candidates the remaining candidates of the
//   anchor are ignored and the result reports skip_stop=1. Without the macro all
//   candidates are compared and skip_stop is tied to 0.
//
// Ports
//   clock, resetn        clock and asynchronous active-low reset
//   ivalid / oready      input beat handshake
//   sc_in, f_j, j_idx    pair score (32'h80000001 = rejected), f[j], j
//   i_idx, self_sc       anchor index and initial f[i] (taken on the first beat)
//   first, last          anchor framing
//   cand_en              beat carries a real candidate
//   ovalid / iready      result handshake
//   f_out, p_out, i_out  best score, best predecessor (all-ones if none), anchor
//   n_cand               candidates compared for the anchor
//   skip_stop            early stop happened for the anchor
module chain_max_select #(
    parameter int IDX_W    = 32,
    parameter int MAX_SKIP = 25
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ivalid,
    output logic             oready,
    input  logic [31:0]      sc_in,
    input  logic [31:0]      f_j,
    input  logic [IDX_W-1:0] j_idx,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      self_sc,
    input  logic             first,
    input  logic             last,
    input  logic             cand_en,
    output logic             ovalid,
    input  logic             iready,
    output logic [31:0]      f_out,
    output logic [IDX_W-1:0] p_out,
    output logic [IDX_W-1:0] i_out,
    output logic [15:0]      n_cand,
    output logic             skip_stop
);

    localparam logic [31:0] REJECT_SC = 32'h80000001;

    // ---------------- stage 1 ----------------
    logic                    s1_valid_reg;
    logic signed [31:0]      s1_cand_reg;
    logic                    s1_cv_reg;
    logic [IDX_W-1:0]        s1_j_reg;
    logic                    s1_first_reg;
    logic                    s1_last_reg;
    logic [IDX_W-1:0]        s1_i_reg;
    logic signed [31:0]      s1_self_reg;

    // ---------------- stage 2 ----------------
    logic signed [31:0]      best_reg;
    logic [IDX_W-1:0]        best_p_reg;
    logic [15:0]             cnt_reg;
    logic                    ovalid_reg;
    logic [31:0]             f_out_reg;
    logic [IDX_W-1:0]        p_out_reg;
    logic [IDX_W-1:0]        i_out_reg;
    logic [15:0]             n_cand_reg;

    logic                    stall;
    logic                    accept;
    logic                    beat_go;
    logic signed [32:0]      sum33;
    logic signed [31:0]      cand_sat;

    logic signed [31:0]      base_best;
    logic [IDX_W-1:0]        base_p;
    logic [15:0]             base_cnt;
    logic                    compare_en;
    logic                    improve;
    logic signed [31:0]      best_next;
    logic [IDX_W-1:0]        best_p_next;
    logic [15:0]             cnt_next;

    // Only a last beat needs the output register, so only it can be blocked
    // by an unconsumed result; the whole front end freezes behind it.
    assign stall   = s1_valid_reg && s1_last_reg && ovalid_reg && !iready;
    assign oready  = !stall;
    assign accept  = ivalid && !stall;
    assign beat_go = s1_valid_reg && !stall;

    // 33-bit sum, clamped into the 32-bit signed range: the top two bits differ
    // only when the true sum is out of range.
    always_comb begin
        sum33    = {f_j[31], f_j} + {sc_in[31], sc_in};
        cand_sat = sum33[31:0];
        if (sum33[32] != sum33[31]) begin
            cand_sat = sum33[32] ? 32'sh80000000 : 32'sh7FFFFFFF;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid_reg <= 1'b0;
            s1_cand_reg  <= '0;
            s1_cv_reg    <= 1'b0;
            s1_j_reg     <= '0;
            s1_first_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_i_reg     <= '0;
            s1_self_reg  <= '0;
        end else if (!stall) begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_cand_reg  <= cand_sat;
                s1_cv_reg    <= cand_en && (sc_in != REJECT_SC);
                s1_j_reg     <= j_idx;
                s1_first_reg <= first;
                s1_last_reg  <= last;
                if (first) begin
                    s1_i_reg    <= i_idx;
                    s1_self_reg <= self_sc;
                end
            end
        end
    end

`ifdef CHAIN_MAX_SKIP_EN
    logic [15:0] skip_reg;
    logic [15:0] base_skip;
    logic [15:0] skip_next;
    logic        skip_stop_reg;

    // Once the run of non-improving candidates reaches MAX_SKIP the rest of
    // the anchor is ignored; a first beat restarts the run.
    always_comb begin
        base_skip  = s1_first_reg ? 16'd0 : skip_reg;
        compare_en = s1_cv_reg && (base_skip < 16'(MAX_SKIP));
        skip_next  = base_skip;
        if (improve) begin
            skip_next = 16'd0;
        end else if (compare_en) begin
            skip_next = base_skip + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            skip_reg      <= '0;
            skip_stop_reg <= 1'b0;
        end else if (beat_go) begin
            skip_reg <= skip_next;
            if (s1_last_reg) begin
                skip_stop_reg <= (skip_next >= 16'(MAX_SKIP));
            end
        end
    end

    assign skip_stop = skip_stop_reg;
`else
    always_comb begin
        compare_en = s1_cv_reg;
    end

    assign skip_stop = 1'b0;
`endif

    // A first beat seeds the accumulator with self_sc and then folds its own
    // candidate; strict > keeps the earlier (nearer) predecessor on ties.
    always_comb begin
        base_best   = s1_first_reg ? s1_self_reg : best_reg;
        base_p      = s1_first_reg ? '1 : best_p_reg;
        base_cnt    = s1_first_reg ? 16'd0 : cnt_reg;
        improve     = compare_en && (s1_cand_reg > base_best);
        best_next   = improve ? s1_cand_reg : base_best;
        best_p_next = improve ? s1_j_reg : base_p;
        cnt_next    = base_cnt + {15'd0, compare_en};
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            best_reg   <= '0;
            best_p_reg <= '0;
            cnt_reg    <= '0;
            ovalid_reg <= 1'b0;
            f_out_reg  <= '0;
            p_out_reg  <= '0;
            i_out_reg  <= '0;
            n_cand_reg <= '0;
        end else begin
            if (beat_go) begin
                best_reg   <= best_next;
                best_p_reg <= best_p_next;
                cnt_reg    <= cnt_next;
            end
            if (beat_go && s1_last_reg) begin
                ovalid_reg <= 1'b1;
                f_out_reg  <= best_next;
                p_out_reg  <= best_p_next;
                i_out_reg  <= s1_i_reg;
                n_cand_reg <= cnt_next;
            end else if (iready) begin
                ovalid_reg <= 1'b0;
            end
        end
    end

    assign ovalid = ovalid_reg;
    assign f_out  = f_out_reg;
    assign p_out  = p_out_reg;
    assign i_out  = i_out_reg;
    assign n_cand = n_cand_reg;

endmodule

// File: tb/tb_chain_max_select.sv
// Directed bench for chain_max_select: linear sequence of beats with
// hand-computed expected results, checked with immediate assertions.
module tb_chain_max_select;

`ifdef CHAIN_MAX_SKIP_EN
    localparam int MS = 2;
`else
    localparam int MS = 25;
`endif

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        ivalid = 1'b0;
    logic        oready;
    logic [31:0] sc_in = '0;
    logic [31:0] f_j = '0;
    logic [31:0] j_idx = '0;
    logic [31:0] i_idx = '0;
    logic [31:0] self_sc = '0;
    logic        first = 1'b0;
    logic        last = 1'b0;
    logic        cand_en = 1'b0;
    logic        ovalid;
    logic        iready = 1'b1;
    logic [31:0] f_out;
    logic [31:0] p_out;
    logic [31:0] i_out;
    logic [15:0] n_cand;
    logic        skip_stop;

    int n_pass = 0;
    int n_total = 0;

    chain_max_select #(.IDX_W(32), .MAX_SKIP(MS)) dut (
        .clock(clock), .resetn(resetn), .ivalid(ivalid), .oready(oready),
        .sc_in(sc_in), .f_j(f_j), .j_idx(j_idx), .i_idx(i_idx),
        .self_sc(self_sc), .first(first), .last(last), .cand_en(cand_en),
        .ovalid(ovalid), .iready(iready), .f_out(f_out), .p_out(p_out),
        .i_out(i_out), .n_cand(n_cand), .skip_stop(skip_stop)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one beat for exactly one edge, then drop ivalid.
    task automatic beat(input logic fst, input logic lst, input logic ce,
                        input logic [31:0] sc, input logic [31:0] fj,
                        input logic [31:0] j, input logic [31:0] i,
                        input logic [31:0] slf);
        ivalid  = 1'b1;
        first   = fst;
        last    = lst;
        cand_en = ce;
        sc_in   = sc;
        f_j     = fj;
        j_idx   = j;
        i_idx   = i;
        self_sc = slf;
        @(posedge clock);
        #1;
        ivalid = 1'b0;
        first  = 1'b0;
        last   = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [31:0] ef, input logic [31:0] ep,
                           input logic [31:0] ei, input logic [15:0] en);
        chk({tag, ".ovalid"}, 64'(ovalid), 64'd1);
        chk({tag, ".f_out"},  64'(f_out),  64'(ef));
        chk({tag, ".p_out"},  64'(p_out),  64'(ep));
        chk({tag, ".i_out"},  64'(i_out),  64'(ei));
        chk({tag, ".n_cand"}, 64'(n_cand), 64'(en));
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.ovalid", 64'(ovalid), 64'd0);
        chk("rst.f_out", 64'(f_out), 64'd0);
        chk("rst.p_out", 64'(p_out), 64'd0);
        chk("rst.i_out", 64'(i_out), 64'd0);
        chk("rst.n_cand", 64'(n_cand), 64'd0);
        chk("rst.skip_stop", 64'(skip_stop), 64'd0);
        resetn = 1'b1;
        tick();
        chk("rst.oready", 64'(oready), 64'd1);

        // Single beat, no candidate: result two edges after accept
        beat(1, 1, 0, 32'd0, 32'd0, 32'd0, 32'd7, 32'd15);
        chk("single.latency", 64'(ovalid), 64'd0);
        tick();
        chk_res("single", 32'd15, 32'hFFFFFFFF, 32'd7, 16'd0);
        chk("single.skip_stop", 64'(skip_stop), 64'd0);
        tick();
        chk("single.consumed", 64'(ovalid), 64'd0);

        // Three beats with a bubble; tie between j=8 and j=7 keeps j=8
        beat(1, 0, 1, 32'd5, 32'd20, 32'd9, 32'd10, 32'd15);
        tick();
        beat(0, 0, 1, 32'd3, 32'd30, 32'd8, 32'd0, 32'd0);
        beat(0, 1, 1, 32'd3, 32'd30, 32'd7, 32'd0, 32'd0);
        tick();
        chk_res("three", 32'd33, 32'd8, 32'd10, 16'd3);
        tick();

        // Rejected pair is not a candidate
        beat(1, 1, 1, 32'h80000001, 32'd100, 32'd3, 32'd4, 32'd12);
        tick();
        chk_res("reject", 32'd12, 32'hFFFFFFFF, 32'd4, 16'd0);
        tick();

        // Positive saturation
        beat(1, 1, 1, 32'h00000100, 32'h7FFFFFF0, 32'd2, 32'd5, 32'd1);
        tick();
        chk_res("sat_pos", 32'h7FFFFFFF, 32'd2, 32'd5, 16'd1);
        tick();

        // Negative saturation: clamped to -2^31, not greater than self_sc
        beat(1, 1, 1, 32'h80000002, 32'h80000000, 32'd2, 32'd6, 32'h80000000);
        tick();
        chk_res("sat_neg", 32'h80000000, 32'hFFFFFFFF, 32'd6, 16'd1);
        tick();

        // Backpressure: A pending, B's last beat in stage 1
        iready = 1'b0;
        beat(1, 1, 1, 32'd5, 32'd5, 32'd50, 32'd100, 32'd1);
        beat(1, 0, 1, 32'd3, 32'd0, 32'd60, 32'd101, 32'd2);
        beat(0, 1, 1, 32'hFFFFFFEC, 32'd10, 32'd59, 32'd0, 32'd0);
        chk("bp.oready_low", 64'(oready), 64'd0);
        chk_res("bp.A", 32'd10, 32'd50, 32'd100, 16'd1);
        tick();
        tick();
        chk("bp.oready_held", 64'(oready), 64'd0);
        chk_res("bp.A_stable", 32'd10, 32'd50, 32'd100, 16'd1);
        iready = 1'b1;
        tick();
        chk_res("bp.B", 32'd3, 32'd60, 32'd101, 16'd2);
        chk("bp.oready_back", 64'(oready), 64'd1);
        tick();
        chk("bp.drained", 64'(ovalid), 64'd0);

        // Abort: open anchor 200 is dropped by the first beat of anchor 201
        beat(1, 0, 1, 32'd0, 32'd1000, 32'd5, 32'd200, 32'd0);
        beat(1, 1, 1, 32'd1, 32'd1, 32'd3, 32'd201, 32'd4);
        chk("abort.no_result", 64'(ovalid), 64'd0);
        tick();
        chk_res("abort", 32'd4, 32'hFFFFFFFF, 32'd201, 16'd1);
        tick();

`ifdef CHAIN_MAX_SKIP_EN
        // Early stop after two non-improving candidates; 90 is ignored
        beat(1, 0, 1, 32'd0, 32'd50, 32'd4, 32'd300, 32'd10);
        beat(0, 0, 1, 32'd0, 32'd40, 32'd3, 32'd0, 32'd0);
        beat(0, 0, 1, 32'd0, 32'd40, 32'd2, 32'd0, 32'd0);
        beat(0, 1, 1, 32'd0, 32'd90, 32'd1, 32'd0, 32'd0);
        tick();
        chk_res("skip", 32'd50, 32'd4, 32'd300, 16'd3);
        chk("skip.skip_stop", 64'(skip_stop), 64'd1);
        tick();
`endif

        // Reset mid-anchor discards the open anchor
        beat(1, 0, 1, 32'd1, 32'd1, 32'd1, 32'd400, 32'd0);
        resetn = 1'b0;
        #1;
        chk("midrst.f_out", 64'(f_out), 64'd0);
        #2;
        resetn = 1'b1;
        tick();
        tick();
        tick();
        chk("midrst.no_result", 64'(ovalid), 64'd0);
        chk("midrst.oready", 64'(oready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/chain_max_select.md
Name: chain_max_select

Overview:
- Chaining DP reduction stage, directly downstream of the per-pair chaining score pipeline.
- Consumes one beat per (anchor i, predecessor j) pair: the pair score plus f[j] and j.
- Folds the beats for one anchor into its best chain score f[i] and predecessor p[i].
- Emits one result per anchor, with backpressure, to the f/p write-back logic.

Parameters:
- IDX_W, 32: width of anchor indices i and j.
- MAX_SKIP, 25: consecutive non-improving candidates tolerated before early stop. Used only with the optional feature.

Ports:
- clock, input, 1: clock.
- resetn, input, 1: asynchronous active-low reset.
- ivalid, input, 1: input beat valid.
- oready, output, 1: block can accept an input beat.
- sc_in, input, 32: signed pair score; 32'h80000001 marks a rejected pair.
- f_j, input, 32: signed f[j] of the predecessor.
- j_idx, input, IDX_W: predecessor index.
- i_idx, input, IDX_W: current anchor index; sampled on the first beat.
- self_sc, input, 32: signed q_span of anchor i, the initial f[i]; sampled on the first beat.
- first, input, 1: first beat of anchor i.
- last, input, 1: last beat of anchor i.
- cand_en, input, 1: beat carries a real candidate; 0 for an anchor with no predecessors.
- ovalid, output, 1: result valid.
- iready, input, 1: downstream accepts the result.
- f_out, output, 32: best score f[i].
- p_out, output, IDX_W: best predecessor; all-ones (-1) if none.
- i_out, output, IDX_W: anchor index of the result.
- n_cand, output, 16: number of candidates compared for this anchor.
- skip_stop, output, 1: early stop occurred.

Behaviour:
- Reset is asynchronous, active-low, on resetn; all logic runs on clock.
- Reset values: ovalid=0, f_out=0, p_out=0, i_out=0, n_cand=0, skip_stop=0. All internal valids and the accumulator clear to 0.
- Handshake rules:
  - A beat is accepted when ivalid && oready.
  - A result transfers when ovalid && iready.
  - oready = ~(s1_valid && s1_last && ovalid && ~iready). It drops only when a last beat sits in stage 1 while an unconsumed result blocks the output register.
- Stage 1, at the edge after accept, registers the following:
  - cand = f_j + sc_in, computed in 33-bit signed.
  - cv = cand_en && (sc_in != 32'h80000001).
  - j, first, last; on a first beat, also i_idx and self_sc.
  - If stage 1 is stalled, it holds its contents.
- Stage 2, the accumulator (best, best_p, cnt):
  - When a first beat leaves stage 1, the accumulator first initialises to best=self_sc, best_p=-1, cnt=0, and that same beat's candidate is then folded in.
  - Fold rule: if cv, then cnt+1. If also cand > best, compared signed and strictly greater, then best=cand and best_p=j.
  - Ties keep the earlier beat. Upstream streams j from i-1 downward, so the nearest predecessor wins a tie.
- Saturation: cand above 32'h7FFFFFFF saturates to 32'h7FFFFFFF before compare. cand below -2^31 saturates to 32'h80000000.
- Output: when the last beat leaves stage 1, the folded result loads f_out, p_out, i_out and n_cand at that edge, and ovalid goes to 1.
- Latency: ovalid rises 2 edges after the last beat is accepted, when there is no stall.
- ovalid holds with stable data until iready; it then clears, unless a new result loads on the same edge.
- A single beat with first=last=1 is legal. Non-last beats never touch the output register.
- Throughput: one beat per cycle. Back-to-back anchors need no bubble.
- A first beat arriving while an anchor is open (no last seen) aborts the open anchor. Its partial result is dropped.
- ivalid=0 cycles insert bubbles only and do not change the accumulator.
- resetn low mid-anchor or mid-stall discards all state. No result is emitted for a partial anchor.

Optional Feature:
- Macro: CHAIN_MAX_SKIP_EN.
- With the macro defined:
  - A skip counter resets on first and on each improvement. It increments on each valid candidate that does not improve best.
  - When the counter reaches MAX_SKIP, later candidates of that anchor are ignored: no compare, and cnt is not incremented.
  - The result carries skip_stop=1. The counter clears on the next first beat.
- Without the macro: all candidates are compared, and skip_stop is tied to 0.

Test Plan:
- Single beat: first=last=1, cand_en=0, self_sc=15, i=7 -> after 2 cycles, f_out=15, p_out=all-ones, n_cand=0, i_out=7.
- Three beats, j=9,8,7, f_j=20,30,30, sc=5,3,3, self_sc=15 -> f_out=33, p_out=8 (the tie with j=7 keeps 8), n_cand=3.
- Rejected pair: sc=32'h80000001 on the only candidate, f_j=100, self_sc=12 -> f_out=12, p_out=-1, n_cand=0.
- Backpressure: iready=0 with a result pending and the next anchor's last beat in stage 1 -> oready=0 and the first result stays stable. iready=1 -> both results emerge in order with no loss.
- Saturation: f_j=32'h7FFFFFF0, sc=32'h00000100 -> f_out=32'h7FFFFFFF.
- CHAIN_MAX_SKIP_EN with MAX_SKIP=2: candidates 50,40,40,90 with self_sc=10 -> f_out=50, n_cand=3, skip_stop=1. The 90 is ignored.
